// File: rtl/wave_synth.sv
// wave_synth: sample-rate waveform generator feeding an 8-bit DAC.
// A 16-bit phase accumulator advances once per sample tick. Its top byte
// selects a square, saw, triangle or DC raw sample, which is then scaled by
// AMPL and offset with saturation in a two-stage registered pipeline.
module wave_synth #(
   parameter int SAMPLE_DIV = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       wr_en_i,
   input  logic [2:0] addr_i,
   input  logic [7:0] data_i,
   output logic [7:0] dac_o,
   output logic       dac_valid_o
);

   localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

   // Register file
   logic        r_ctrl_en;
   logic [1:0]  r_wsel;
   logic [7:0]  r_ftw_stage;
   logic [15:0] r_ftw;
   logic [7:0]  r_ampl;
   logic [7:0]  r_offset;
   logic [7:0]  r_duty;

   // Datapath state
   logic [15:0] r_div;
   logic [15:0] r_phase;
   logic        r_s1_valid;
   logic [7:0]  r_s1_data;
   logic [7:0]  r_dac;
   logic        r_dac_valid;

   logic        w_run;
   logic        w_tick;
   logic [7:0]  w_p;
   logic [7:0]  w_tri;
   logic [7:0]  w_raw;
   logic [8:0]  w_ampl_p1;
   logic [15:0] w_prod;
   logic [7:0]  w_scaled;
   logic [8:0]  w_sum;
   logic [7:0]  w_sat;

   assign w_run  = en_i & r_ctrl_en;
   assign w_tick = w_run & (r_div == DIV_LAST);
   assign w_p    = r_phase[15:8];

   // Triangle folds the upper half of the phase back down
   assign w_tri  = w_p[7] ? ~{w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};

   // Raw sample selection from the current phase
   always_comb begin
      w_raw = 8'h00;
      case (r_wsel)
         2'b00:   w_raw = (w_p < r_duty) ? 8'hFF : 8'h00;
         2'b01:   w_raw = w_p;
         2'b10:   w_raw = w_tri;
         default: w_raw = 8'hFF;
      endcase
   end

   // Scaling by (AMPL+1)/256; the 16-bit product cannot overflow (255*256)
   assign w_ampl_p1 = {1'b0, r_ampl} + 9'd1;
   assign w_prod    = {8'd0, w_raw} * {7'd0, w_ampl_p1};
   assign w_scaled  = 8'(w_prod >> 8);

   // Offset with saturation at full scale
   assign w_sum = {1'b0, r_s1_data} + {1'b0, r_offset};
   assign w_sat = w_sum[8] ? 8'hFF : w_sum[7:0];

   // Register writes; FTW_HI commits the staged low byte atomically
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl_en   <= 1'b0;
         r_wsel      <= 2'b00;
         r_ftw_stage <= 8'h00;
         r_ftw       <= 16'h0100;
         r_ampl      <= 8'hFF;
         r_offset    <= 8'h00;
         r_duty      <= 8'h80;
      end else if (wr_en_i) begin
         case (addr_i)
            3'd0: begin
               r_ctrl_en <= data_i[0];
               r_wsel    <= data_i[2:1];
            end
            3'd1:    r_ftw_stage <= data_i;
            3'd2:    r_ftw       <= {data_i, r_ftw_stage};
            3'd3:    r_ampl      <= data_i;
            3'd4:    r_offset    <= data_i;
            3'd5:    r_duty      <= data_i;
            default: ;
         endcase
      end
   end

   // Sample divider and phase accumulator, both held at zero while stopped
   always_ff @(posedge clk) begin
      if (rst || !w_run) begin
         r_div   <= 16'd0;
         r_phase <= 16'd0;
      end else begin
         r_div <= (r_div == DIV_LAST) ? 16'd0 : r_div + 16'd1;
         if (w_tick) begin
            r_phase <= r_phase + r_ftw;
         end
      end
   end

   // Stage 1: capture the scaled sample on tick
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= 8'h00;
      end else begin
         r_s1_valid <= w_tick;
         if (w_tick) begin
            r_s1_data <= w_scaled;
         end
      end
   end

   // Stage 2: offset, saturate and present to the DAC; stopping flushes to 00
   always_ff @(posedge clk) begin
      if (rst || !w_run) begin
         r_dac       <= 8'h00;
         r_dac_valid <= 1'b0;
      end else begin
         r_dac_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_dac <= w_sat;
         end
      end
   end

   assign dac_o       = r_dac;
   assign dac_valid_o = r_dac_valid;

endmodule

// File: doc/wave_synth.md
# wave_synth

Sample-rate waveform synthesizer driving the 8-bit DAC output of the digital core. It sits downstream of the UART register FSM and receives byte-wide register writes plus a run enable. It generates square, sawtooth, triangle or DC samples from a 16-bit phase accumulator, then applies amplitude scaling and a saturating offset. Each sample is presented as a registered `dac_o` byte with a one-cycle `dac_valid_o` strobe.

## Interface
- `SAMPLE_DIV`, 50: clocks per output sample (1 MS/s at 50 MHz); legal range 1..65535.
- `clk` in 1: system clock.
- `rst` in 1: reset, **synchronous, active-high**; one clock domain only.
- `en_i` in 1: run enable from the register FSM; ANDed with `CTRL.en`.
- `wr_en_i` in 1: register write strobe, one cycle per write.
- `addr_i` in 3: register address.
- `data_i` in 8: register write data.
- `dac_o` out 8: DAC sample, registered.
- `dac_valid_o` out 1: one-cycle pulse when `dac_o` takes a new sample.

## Operation
- Register map (write-only; reset value in brackets):
  - 0 `CTRL`: bit0 `en` [0], bits2:1 `wsel` [00]; 00 = square, 01 = saw, 10 = triangle, 11 = DC.
  - 1 `FTW_LO` [00]: written to a staging byte only.
  - 2 `FTW_HI`: commits `ftw = {data_i, staging}` atomically. `ftw` resets to 0x0100.
  - 3 `AMPL` [FF].
  - 4 `OFFSET` [00].
  - 5 `DUTY` [80].
  - Addresses 6–7: writes are ignored.
- `run = en_i & CTRL.en`.
- Divider counts 0..SAMPLE_DIV-1 while `run` is high. `tick` is asserted when the count equals SAMPLE_DIV-1. With SAMPLE_DIV = 1, `tick` is asserted every cycle.
- On `tick`:
  - The raw sample is computed from the current `phase[15:8]` (call it `p`).
  - `phase <= phase + ftw`, modulo 2^16; wrap is silent.
- Raw sample by waveform:
  - Square: `p < DUTY ? FF : 00`. DUTY = 0 gives all zeros; DUTY = FF gives FF for every p except FF.
  - Saw: `p`.
  - Triangle: `p[7] ? ~{p[6:0],0} : {p[6:0],0}`.
  - DC: `FF`.
- Stage 1 (registered on `tick`): `scaled = (raw * (AMPL+1)) >> 8`. The product is 8×9 bits; the result is 8 bits. With AMPL = FF the raw value passes unchanged.
- Stage 2 (registered the next cycle): `sum = scaled + OFFSET` at 9 bits. `dac_o = sum[8] ? FF : sum[7:0]`, and `dac_valid_o = 1`.
- When `run` is low:
  - Divider and phase are cleared to 0.
  - The pipeline valid flags are cleared.
  - `dac_o` is set to 00 on the next edge; no `dac_valid_o` pulses occur.
- Register writes are never blocked and take effect on the clock after `wr_en_i`. If a write and a `tick` occur in the same cycle, the `tick` uses the old register values.
- Changing `ftw` or `wsel` while running does not reset the phase.

## Timing
- Reset values: `dac_o` = 00, `dac_valid_o` = 0, phase = 0, divider = 0, staging = 00, registers as in the map.
- Reset asserted mid-operation: all of the above apply on the next edge; any in-flight sample is dropped.
- `run` rising in cycle R: the first `tick` occurs in cycle R+SAMPLE_DIV-1 and samples phase 0.
- Latency: `tick` in cycle N → stage 1 at the end of N → `dac_o` / `dac_valid_o` visible in cycle N+2.
- Valid pulses: one per `tick`, spaced exactly SAMPLE_DIV cycles apart. `dac_o` holds its value between pulses.
- `run` falling: the divider and pipeline are flushed on the next edge; a sample due in the following 2 cycles is not emitted.

## Test plan
- **Reset and idle:** assert `rst` 3 cycles, `en_i` = 1, `CTRL` = 0 → `dac_o` = 00 and no `dac_valid_o` for 200 cycles.
- **Saw:** SAMPLE_DIV = 4, `ftw` = 0x0100, `CTRL` = 0x03.
  - `dac_valid_o` every 4 cycles.
  - `dac_o` sequence 00, 01, 02 … FF, 00 (wrap).
  - First valid occurs 5 cycles after the `CTRL` write takes effect.
- **Square:** `ftw` = 0x1000, DUTY = 0x40, `wsel` = 00 → repeating FF×4, 00×12.
- **Triangle:** `ftw` = 0x0800, `wsel` = 10 → 00, 10, 20 … F0, FF, EF, DF … 0F, then repeats.
- **Scale/saturate:** DC waveform.
  - AMPL = 7F → 7F.
  - Adding OFFSET = 40 → BF.
  - OFFSET = A0 → FF (saturated).
- **FTW staging and disable:**
  - Write `FTW_LO` = 00 alone → step size unchanged.
  - Then write `FTW_HI` = 02 → saw step becomes 2.
  - Drop `en_i` mid-stream → `dac_o` = 00 next cycle, no further valid pulses.
  - Re-raise `en_i` → output restarts at 00.
